sfu_accum: RTL and testbench
============================

Name: sfu_accum

Overview:
- Special-function stage downstream of the psum SRAM. It consumes 8-column x 16-bit partial-sum rows read back from pmem and accumulates acc_len consecutive rows per output pixel (one row per kernel position).
- Applies optional ReLU and saturation, then presents one finished output row with a valid/ready handshake for the output-feature writeback path.
- One instance per core, operating on all columns in parallel.

Parameters:
- col, 8, number of columns (lanes) per row
- psum_bw, 16, signed psum width per lane, in and out
- guard_bw, 4, extra accumulator guard bits; acc width = psum_bw+guard_bw

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- acc_len  input  4  rows to accumulate per output; sampled on the first beat of a group; 0 is treated as 1
- relu_en  input  1  ReLU enable; sampled with acc_len
- in_valid  input  1  in_data beat present
- in_ready  output  1  block accepts a beat this cycle
- in_data  input  col*psum_bw  psum row, lane i at [psum_bw*(i+1)-1:psum_bw*i], two's complement
- out_valid  output  1  out_data holds a finished row
- out_ready  input  1  consumer takes out_data
- out_data  output  col*psum_bw  finished row, same lane packing
- busy  output  1  high in ACC or OUT

Behaviour:
- A beat is accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Reset (reset==0, async) forces:
  - state=IDLE, all accumulators 0, cnt=0
  - in_ready=1, out_valid=0, out_data=0, busy=0
- Reset mid-group discards partial sums; no output is produced for that group.
- States:
  - IDLE (in_ready=1):
    - On an accepted beat: acc[i]=sext(in[i]), cnt=1, len=max(acc_len,1), relu latched.
    - If len==1 go to OUT, else ACC.
  - ACC (in_ready=1):
    - Each accepted beat: acc[i]+=sext(in[i]), cnt+=1.
    - On the beat where cnt becomes len, go to OUT.
    - No beat: hold state and accumulators.
  - OUT (in_ready=0, out_valid=1):
    - out_data is registered and stable until the transfer.
    - On transfer: go to IDLE, clear accumulators, and drop out_valid the next cycle.
    - Without out_ready: hold indefinitely. Beats offered during OUT are not accepted (upstream must hold them).
- Latency: the last beat accepted at edge t gives out_valid=1 after edge t (visible cycle t+1).
  - Minimum group period: len+1 cycles, i.e. one bubble for the OUT cycle.
- Result per lane, computed combinationally from the final acc and registered on entry to OUT:
  - Step 1, saturate: r = sat(acc) to [-2^(psum_bw-1), 2^(psum_bw-1)-1] (see Optional Feature).
  - Step 2, ReLU: if relu latched and r<0 then r=0.
- Lanes are fully independent; no cross-lane arithmetic.
- The accumulator must not overflow: guard_bw=4 covers up to 15 worst-case 16-bit addends.
- acc_len or relu_en changes mid-group are ignored until the next group.
- cnt is 4 bits and never wraps, since len<=15.

Optional Feature:
- Macro: SFU_SAT_EN
- Defined: step 1 clamps each lane to the signed psum_bw range as above.
- Undefined: step 1 truncates to the low psum_bw bits of acc (two's-complement wrap). There is no clamp logic.
- ReLU is applied after step 1 in both builds.

Test Plan:
- Reset: hold reset=0 while driving in_valid=1 with random data -> out_valid=0, out_data=0, in_ready=1, busy=0. Release reset -> first accepted beat starts a group.
- Basic 3x3: acc_len=9, relu_en=0, 9 back-to-back beats with every lane = lane index i -> out_valid exactly 1 cycle after the 9th beat; lane i = 9*i; in_ready=0 during OUT.
- ReLU and sign: acc_len=2, relu_en=1, lane0 beats -5,+3 and lane1 beats +7,-2 -> lane0=0, lane1=5. With relu_en=0 -> lane0=-2 (16'hFFFE).
- Saturation: acc_len=4, all lanes 16'h7000 x4 (sum 0x1C000) -> with SFU_SAT_EN lanes=16'h7FFF. Without the macro lanes=16'hC000. All lanes 16'h8000 x2 with SFU_SAT_EN -> 16'h8000.
- Backpressure and bubbles: acc_len=3, in_valid toggled 1,0,1,0,1 -> sum uses only accepted beats. Hold out_ready=0 for 5 cycles -> out_data stable and in_ready=0. Set out_ready=1 -> one transfer, IDLE next cycle, next group accumulates from zero.
- Edge cases:
  - acc_len=0 with one beat of 16'h0012 -> output 16'h0012 after one beat.
  - Assert reset for one cycle after 4 of 9 beats -> no output. A fresh 9-beat group then produces only its own sum.

Source files
------------

// File: rtl/sfu_accum.sv
// Accumulates acc_len psum rows per lane, then applies saturate/wrap and ReLU.
// Latency: last beat accepted at edge t -> out_valid after t; in_ready low while a row is held in OUT.
// Saturation is built only with `define SFU_SAT_EN; otherwise lanes wrap to psum_bw bits.
module sfu_accum #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int guard_bw = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             acc_len,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   busy
);

    localparam int ACC_W = psum_bw + guard_bw;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q [col];
    logic signed [ACC_W-1:0]  acc_d [col];
    logic [3:0]               cnt_q, cnt_d;
    logic [3:0]               len_q, len_d;
    logic                     relu_q, relu_d;
    logic [col*psum_bw-1:0]   out_q;
    logic [col*psum_bw-1:0]   res;
    logic                     beat;
    logic                     xfer;

    function automatic logic signed [ACC_W-1:0] sext(input logic [psum_bw-1:0] v);
        return {{guard_bw{v[psum_bw-1]}}, v};
    endfunction

    assign in_ready  = (state_q != OUT);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;
    assign beat      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        relu_d  = relu_q;
        for (int i = 0; i < col; i++) acc_d[i] = acc_q[i];
        case (state_q)
            IDLE: begin
                if (beat) begin
                    for (int i = 0; i < col; i++) acc_d[i] = sext(in_data[i*psum_bw +: psum_bw]);
                    cnt_d   = 4'd1;
                    len_d   = (acc_len == 4'd0) ? 4'd1 : acc_len;
                    relu_d  = relu_en;
                    state_d = (len_d == 4'd1) ? OUT : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    for (int i = 0; i < col; i++) acc_d[i] = acc_q[i] + sext(in_data[i*psum_bw +: psum_bw]);
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == len_q) state_d = OUT;
                end
            end
            OUT: begin
                if (xfer) begin
                    for (int i = 0; i < col; i++) acc_d[i] = '0;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SFU_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (psum_bw-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    // Result is taken from the next-state accumulator so the final beat is included.
    always_comb begin
        res = '0;
        for (int i = 0; i < col; i++) begin
`ifdef SFU_SAT_EN
            if (acc_d[i] > SAT_MAX)
                res[i*psum_bw +: psum_bw] = SAT_MAX[psum_bw-1:0];
            else if (acc_d[i] < SAT_MIN)
                res[i*psum_bw +: psum_bw] = SAT_MIN[psum_bw-1:0];
            else
                res[i*psum_bw +: psum_bw] = acc_d[i][psum_bw-1:0];
`else
            res[i*psum_bw +: psum_bw] = acc_d[i][psum_bw-1:0];
`endif
            if (relu_d && res[i*psum_bw + psum_bw-1])
                res[i*psum_bw +: psum_bw] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            len_q   <= 4'd1;
            relu_q  <= 1'b0;
            out_q   <= '0;
            for (int i = 0; i < col; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
            for (int i = 0; i < col; i++) acc_q[i] <= acc_d[i];
            if (state_d == OUT && state_q != OUT) out_q <= res;
        end
    end

endmodule

// File: tb/tb_sfu_accum.sv
// Directed bench for sfu_accum: reset, accumulation, ReLU, saturation/wrap, backpressure, edge cases.
module tb_sfu_accum;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int DW  = COL * PBW;

    logic          clk;
    logic          reset;
    logic [3:0]    acc_len;
    logic          relu_en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int tests_run;
    int tests_failed;

    sfu_accum #(.col(COL), .psum_bw(PBW), .guard_bw(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_len   (acc_len),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] all_lanes(input logic [PBW-1:0] v);
        logic [DW-1:0] d;
        for (int i = 0; i < COL; i++) d[i*PBW +: PBW] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] lane_idx(input int mul);
        logic [DW-1:0] d;
        for (int i = 0; i < COL; i++) d[i*PBW +: PBW] = PBW'(mul * i);
        return d;
    endfunction

    function automatic logic [DW-1:0] two_lanes(input logic [PBW-1:0] l0, input logic [PBW-1:0] l1);
        logic [DW-1:0] d;
        d = '0;
        d[0 +: PBW]   = l0;
        d[PBW +: PBW] = l1;
        return d;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
            tests_run++;
            if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data got %h exp 0", out_data); end
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
            tests_run++;
            if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        acc_len = 4'd1;
        relu_en = 1'b0;
        send_beat(all_lanes(16'h0005));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(16'h0005)) begin
            tests_failed++;
            $display("FAIL reset_first_group got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(16'h0005));
        end
        drain();
    endtask

    task automatic test_basic();
        acc_len = 4'd9;
        relu_en = 1'b0;
        for (int k = 0; k < 8; k++) send_beat(lane_idx(1));
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL basic_before_last got v=%b busy=%b exp v=0 busy=1", out_valid, busy);
        end
        send_beat(lane_idx(1));
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency got %b exp 1", out_valid); end
        tests_run++;
        if (out_data !== lane_idx(9)) begin tests_failed++; $display("FAIL basic_sum got %h exp %h", out_data, lane_idx(9)); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_in_ready_out got %b exp 0", in_ready); end
        drain();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL basic_after_xfer got v=%b busy=%b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_relu();
        acc_len = 4'd2;
        relu_en = 1'b1;
        send_beat(two_lanes(16'hFFFB, 16'h0007));
        relu_en = 1'b0;
        send_beat(two_lanes(16'h0003, 16'hFFFE));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== two_lanes(16'h0000, 16'h0005)) begin
            tests_failed++; $display("FAIL relu_on got v=%b %h exp v=1 %h", out_valid, out_data, two_lanes(16'h0000, 16'h0005));
        end
        drain();
        relu_en = 1'b0;
        send_beat(two_lanes(16'hFFFB, 16'h0007));
        send_beat(two_lanes(16'h0003, 16'hFFFE));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== two_lanes(16'hFFFE, 16'h0005)) begin
            tests_failed++; $display("FAIL relu_off got v=%b %h exp v=1 %h", out_valid, out_data, two_lanes(16'hFFFE, 16'h0005));
        end
        drain();
    endtask

    task automatic test_sat();
        logic [PBW-1:0] exp_pos, exp_neg;
`ifdef SFU_SAT_EN
        exp_pos = 16'h7FFF;
        exp_neg = 16'h8000;
`else
        exp_pos = 16'hC000;
        exp_neg = 16'h0000;
`endif
        acc_len = 4'd4;
        relu_en = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(all_lanes(16'h7000));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(exp_pos)) begin
            tests_failed++; $display("FAIL sat_pos got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(exp_pos));
        end
        drain();
        acc_len = 4'd2;
        for (int k = 0; k < 2; k++) send_beat(all_lanes(16'h8000));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(exp_neg)) begin
            tests_failed++; $display("FAIL sat_neg got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(exp_neg));
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] pat [5];
        logic          vld [5];
        pat[0] = all_lanes(16'd1);   vld[0] = 1'b1;
        pat[1] = all_lanes(16'd100); vld[1] = 1'b0;
        pat[2] = all_lanes(16'd2);   vld[2] = 1'b1;
        pat[3] = all_lanes(16'd100); vld[3] = 1'b0;
        pat[4] = all_lanes(16'd3);   vld[4] = 1'b1;
        acc_len = 4'd3;
        relu_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = vld[k];
            in_data  = pat[k];
            @(posedge clk); #1;
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(16'd6)) begin
            tests_failed++; $display("FAIL bp_sum got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(16'd6));
        end
        in_valid = 1'b1;
        in_data  = all_lanes(16'd77);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== all_lanes(16'd6) || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold got v=%b rdy=%b %h exp v=1 rdy=0 %h", out_valid, in_ready, out_data, all_lanes(16'd6));
            end
        end
        in_valid = 1'b0;
        drain();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_idle got v=%b busy=%b rdy=%b exp 0 0 1", out_valid, busy, in_ready);
        end
        acc_len = 4'd2;
        send_beat(all_lanes(16'd4));
        send_beat(all_lanes(16'd5));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(16'd9)) begin
            tests_failed++; $display("FAIL bp_next_group got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(16'd9));
        end
        drain();
    endtask

    task automatic test_len0();
        acc_len = 4'd0;
        relu_en = 1'b0;
        send_beat(all_lanes(16'h0012));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(16'h0012)) begin
            tests_failed++; $display("FAIL len0 got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(16'h0012));
        end
        drain();
    endtask

    task automatic test_reset_midgroup();
        acc_len = 4'd9;
        relu_en = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(all_lanes(16'd10));
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_state got v=%b busy=%b exp 0 0", out_valid, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_release got v=%b busy=%b exp 0 0", out_valid, busy);
        end
        for (int k = 0; k < 9; k++) send_beat(all_lanes(16'd1));
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== all_lanes(16'd9)) begin
            tests_failed++; $display("FAIL midreset_fresh got v=%b %h exp v=1 %h", out_valid, out_data, all_lanes(16'd9));
        end
        drain();
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b0;
        acc_len      = 4'd0;
        relu_en      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        #1;
        test_reset();
        test_basic();
        test_relu();
        test_sat();
        test_backpressure();
        test_len0();
        test_reset_midgroup();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
